// File: rtl/io_port_pkg.sv
// Shared constants for the datapath IO port bridge and its FIFOs.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_port_pkg;

    // Default width of every data path.
    localparam int DATA_WIDTH  = 32;
    // Default entries per FIFO. Must be a power of two and at least 2.
    localparam int FIFO_DEPTH  = 4;
    // Read and write pointers need log2(depth) bits.
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    // The level needs one extra bit so that a full FIFO (level == depth) is representable.
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;

    // Level width for an arbitrary depth, used when the bridge is re-parameterised.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous show-ahead FIFO: the head word is on head_data whenever empty=0.
// Latency: a word pushed into an empty FIFO is visible one cycle after the push edge.
// Backpressure: push ignored when full unless popping in the same cycle; pop ignored when empty.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_data      write request and word
//   pop                  read request (consumes head_data)
//   head_data            current head word (undefined contents when empty)
//   full, empty, level   occupancy status, all derived from registered state
module io_fifo
    import io_port_pkg::*;
#(
    parameter int WIDTH = io_port_pkg::DATA_WIDTH,
    parameter int DEPTH = io_port_pkg::FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Show-ahead: the head entry is read combinationally from the storage array.
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset: stale words are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// Bridges a datapath out/in port pair to valid/ready streams via a TX and an RX FIFO.
// Latency: one cycle from push edge to the word being visible on either side.
// Backpressure: TX drops strobes when full (sticky tx_overflow); RX deasserts ext_rx_ready when full.
//
// Ports:
//   clk, clear                         clock, asynchronous active-low reset
//   cpu_out_data, cpu_out_strobe       datapath out-port writes into TX
//   cpu_in_data, cpu_in_ready, cpu_in_ack   datapath in-port view of RX head
//   ext_tx_data/valid/ready            TX stream to the external consumer
//   ext_rx_data/valid/ready            RX stream from the external producer
//   tx_level, rx_level                 FIFO occupancy
//   tx_overflow, rx_underflow          sticky error flags, cleared only by reset
module io_port_bridge #(
    parameter int DATA_WIDTH  = io_port_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH  = io_port_pkg::FIFO_DEPTH,
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  clear,

    input  logic [DATA_WIDTH-1:0] cpu_out_data,
    input  logic                  cpu_out_strobe,

    output logic [DATA_WIDTH-1:0] cpu_in_data,
    output logic                  cpu_in_ready,
    input  logic                  cpu_in_ack,

    output logic [DATA_WIDTH-1:0] ext_tx_data,
    output logic                  ext_tx_valid,
    input  logic                  ext_tx_ready,

    input  logic [DATA_WIDTH-1:0] ext_rx_data,
    input  logic                  ext_rx_valid,
    output logic                  ext_rx_ready,

    output logic [LEVEL_W-1:0]    tx_level,
    output logic [LEVEL_W-1:0]    rx_level,
    output logic                  tx_overflow,
    output logic                  rx_underflow
);

    import io_port_pkg::*;

    logic [DATA_WIDTH-1:0] tx_head;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_push;
    logic                  tx_pop;

    logic [DATA_WIDTH-1:0] rx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic                  rx_push;
    logic                  rx_pop;

    // Goes high on the first clock edge after reset release; holds ext_rx_ready low in reset.
    logic run_q,          run_d;
    logic tx_overflow_q,  tx_overflow_d;
    logic rx_underflow_q, rx_underflow_d;

    // ---------------- TX side: datapath out port -> external consumer ----------------
    assign ext_tx_valid = !tx_empty;
    assign ext_tx_data  = tx_empty ? '0 : tx_head;
    assign tx_pop       = ext_tx_valid && ext_tx_ready;
    // A full FIFO still accepts a strobe when the consumer frees a slot on the same edge.
    assign tx_push      = cpu_out_strobe && (!tx_full || tx_pop);

    // ---------------- RX side: external producer -> datapath in port -----------------
    assign ext_rx_ready = run_q && !rx_full;
    assign rx_push      = ext_rx_valid && ext_rx_ready;
    assign rx_pop       = cpu_in_ack && !rx_empty;
    assign cpu_in_ready = !rx_empty;
    // The datapath sees zero rather than a stale word whenever nothing is buffered.
    assign cpu_in_data  = rx_empty ? '0 : rx_head;

    assign tx_overflow  = tx_overflow_q;
    assign rx_underflow = rx_underflow_q;

    always_comb begin
        run_d          = 1'b1;
        tx_overflow_d  = tx_overflow_q;
        rx_underflow_d = rx_underflow_q;
        if (cpu_out_strobe && tx_full && !tx_pop) begin
            tx_overflow_d = 1'b1;
        end
        if (cpu_in_ack && rx_empty) begin
            rx_underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            run_q          <= 1'b0;
            tx_overflow_q  <= 1'b0;
            rx_underflow_q <= 1'b0;
        end else begin
            run_q          <= run_d;
            tx_overflow_q  <= tx_overflow_d;
            rx_underflow_q <= rx_underflow_d;
        end
    end

    io_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (clear),
        .push      (tx_push),
        .push_data (cpu_out_data),
        .pop       (tx_pop),
        .head_data (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level)
    );

    io_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (clear),
        .push      (rx_push),
        .push_data (ext_rx_data),
        .pop       (rx_pop),
        .head_data (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level)
    );

endmodule

// File: tb/tb_io_port_bridge.sv
// Scoreboard bench for io_port_bridge: stimulus pushes expected words, monitors pop and compare.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_io_port_bridge;

    localparam int DW = 32;
    localparam int LW = 3;

    logic          clk;
    logic          clear;
    logic [DW-1:0] cpu_out_data;
    logic          cpu_out_strobe;
    logic [DW-1:0] cpu_in_data;
    logic          cpu_in_ready;
    logic          cpu_in_ack;
    logic [DW-1:0] ext_tx_data;
    logic          ext_tx_valid;
    logic          ext_tx_ready;
    logic [DW-1:0] ext_rx_data;
    logic          ext_rx_valid;
    logic          ext_rx_ready;
    logic [LW-1:0] tx_level;
    logic [LW-1:0] rx_level;
    logic          tx_overflow;
    logic          rx_underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] tx_exp[$];
    logic [DW-1:0] rx_exp[$];

    io_port_bridge #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .clear          (clear),
        .cpu_out_data   (cpu_out_data),
        .cpu_out_strobe (cpu_out_strobe),
        .cpu_in_data    (cpu_in_data),
        .cpu_in_ready   (cpu_in_ready),
        .cpu_in_ack     (cpu_in_ack),
        .ext_tx_data    (ext_tx_data),
        .ext_tx_valid   (ext_tx_valid),
        .ext_tx_ready   (ext_tx_ready),
        .ext_rx_data    (ext_rx_data),
        .ext_rx_valid   (ext_rx_valid),
        .ext_rx_ready   (ext_rx_ready),
        .tx_level       (tx_level),
        .rx_level       (rx_level),
        .tx_overflow    (tx_overflow),
        .rx_underflow   (rx_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; monitors sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every word the DUT hands to the external consumer.
    always @(negedge clk) begin
        if (ext_tx_valid && ext_tx_ready) begin
            if (tx_exp.size() == 0) begin
                check("tx_unexpected_word", ext_tx_data, 32'hXXXX_XXXX);
            end else begin
                check("tx_word", ext_tx_data, tx_exp.pop_front());
            end
        end
    end

    // Monitor: every word the datapath consumes from the in port.
    always @(negedge clk) begin
        if (cpu_in_ready && cpu_in_ack) begin
            if (rx_exp.size() == 0) begin
                check("rx_unexpected_word", cpu_in_data, 32'hXXXX_XXXX);
            end else begin
                check("rx_word", cpu_in_data, rx_exp.pop_front());
            end
        end
    end

    task automatic strobe(input logic [DW-1:0] d, input bit expect_accept);
        cpu_out_data   = d;
        cpu_out_strobe = 1'b1;
        if (expect_accept) tx_exp.push_back(d);
        step();
        cpu_out_strobe = 1'b0;
    endtask

    task automatic rx_send(input logic [DW-1:0] d);
        ext_rx_data  = d;
        ext_rx_valid = 1'b1;
        rx_exp.push_back(d);
        step();
        ext_rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        step();
        step();
        clear = 1'b1;
        step();
    endtask

    initial begin
        clear          = 1'b0;
        cpu_out_data   = '0;
        cpu_out_strobe = 1'b0;
        cpu_in_ack     = 1'b0;
        ext_tx_ready   = 1'b0;
        ext_rx_data    = '0;
        ext_rx_valid   = 1'b0;

        // Reset state.
        step();
        check("rst_tx_valid",     32'(ext_tx_valid), 32'd0);
        check("rst_cpu_in_ready", 32'(cpu_in_ready), 32'd0);
        check("rst_cpu_in_data",  cpu_in_data,       32'd0);
        check("rst_rx_ready",     32'(ext_rx_ready), 32'd0);
        check("rst_levels",       32'({tx_level, rx_level}), 32'd0);
        check("rst_flags",        32'({tx_overflow, rx_underflow}), 32'd0);
        clear = 1'b1;
        step();
        check("rel_rx_ready",     32'(ext_rx_ready), 32'd1);

        // Single word through TX with the consumer ready.
        ext_tx_ready = 1'b1;
        check("a5_valid_before",  32'(ext_tx_valid), 32'd0);
        strobe(32'h0000_00A5, 1'b1);
        check("a5_valid_next",    32'(ext_tx_valid), 32'd1);
        check("a5_data_next",     ext_tx_data,       32'h0000_00A5);
        step();
        check("a5_level_after",   32'(tx_level), 32'd0);
        ext_tx_ready = 1'b0;

        // Overfill TX: fifth strobe dropped and flagged.
        for (int i = 1; i <= 5; i++) strobe(DW'(i), i <= 4);
        check("ovf_level",        32'(tx_level),    32'd4);
        check("ovf_flag",         32'(tx_overflow), 32'd1);
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("ovf_drained",      32'(tx_level), 32'd0);
        ext_tx_ready = 1'b0;
        check("ovf_sticky",       32'(tx_overflow), 32'd1);

        // Push into a full TX while it pops: accepted, level held, no overflow.
        do_reset();
        for (int i = 0; i < 4; i++) strobe(32'h11 + DW'(i), 1'b1);
        ext_tx_ready = 1'b1;
        strobe(32'h9, 1'b1);
        check("fullpop_level",    32'(tx_level),    32'd4);
        check("fullpop_no_ovf",   32'(tx_overflow), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("fullpop_drained",  32'(tx_level), 32'd0);
        ext_tx_ready = 1'b0;

        // RX show-ahead and in-port acknowledge.
        rx_send(32'hDEAD_BEEF);
        rx_send(32'h1234_5678);
        check("rx_ready_2",       32'(cpu_in_ready), 32'd1);
        check("rx_head_1",        cpu_in_data,       32'hDEAD_BEEF);
        check("rx_level_2",       32'(rx_level),     32'd2);
        cpu_in_ack = 1'b1;
        step();
        cpu_in_ack = 1'b0;
        check("rx_head_2",        cpu_in_data, 32'h1234_5678);
        cpu_in_ack = 1'b1;
        step();
        cpu_in_ack = 1'b0;
        check("rx_empty_ready",   32'(cpu_in_ready), 32'd0);
        check("rx_empty_data",    cpu_in_data,       32'd0);

        // Ack on empty RX.
        check("rx_no_underflow",  32'(rx_underflow), 32'd0);
        cpu_in_ack = 1'b1;
        step();
        cpu_in_ack = 1'b0;
        check("rx_underflow",     32'(rx_underflow), 32'd1);
        check("rx_underflow_lvl", 32'(rx_level),     32'd0);

        // Simultaneous RX push and pop keeps the level and the order.
        rx_send(32'hA1);
        ext_rx_data  = 32'hA2;
        ext_rx_valid = 1'b1;
        rx_exp.push_back(32'hA2);
        cpu_in_ack   = 1'b1;
        step();
        ext_rx_valid = 1'b0;
        cpu_in_ack   = 1'b0;
        check("rx_pp_level",      32'(rx_level),  32'd1);
        check("rx_pp_head",       cpu_in_data,    32'hA2);
        cpu_in_ack = 1'b1;
        step();
        cpu_in_ack = 1'b0;

        // Fill RX; a pop reopens ext_rx_ready on the next cycle.
        for (int i = 0; i < 4; i++) rx_send(32'h100 + DW'(i));
        check("rx_full_ready",    32'(ext_rx_ready), 32'd0);
        check("rx_full_level",    32'(rx_level),     32'd4);
        cpu_in_ack = 1'b1;
        step();
        cpu_in_ack = 1'b0;
        check("rx_reopen_ready",  32'(ext_rx_ready), 32'd1);
        rx_send(32'h104);
        check("rx_refull_level",  32'(rx_level), 32'd4);

        // Buffer some TX words too, then reset asynchronously in mid-cycle.
        strobe(32'h77, 1'b1);
        strobe(32'h78, 1'b1);
        check("pre_rst_tx_level", 32'(tx_level), 32'd2);
        #1;
        clear = 1'b0;
        tx_exp.delete();
        rx_exp.delete();
        #1;
        check("mid_rst_tx_valid",  32'(ext_tx_valid), 32'd0);
        check("mid_rst_cpu_ready", 32'(cpu_in_ready), 32'd0);
        check("mid_rst_cpu_data",  cpu_in_data,       32'd0);
        check("mid_rst_rx_ready",  32'(ext_rx_ready), 32'd0);
        check("mid_rst_levels",    32'({tx_level, rx_level}), 32'd0);
        check("mid_rst_flags",     32'({tx_overflow, rx_underflow}), 32'd0);
        step();
        clear = 1'b1;
        step();
        check("post_rst_rx_ready", 32'(ext_rx_ready), 32'd1);
        check("post_rst_cpu_rdy",  32'(cpu_in_ready), 32'd0);
        ext_tx_ready = 1'b1;
        step();
        step();
        check("post_rst_no_tx",    32'(ext_tx_valid), 32'd0);
        ext_tx_ready = 1'b0;

        // Every expected word must have been observed.
        check("tx_exp_left", 32'(tx_exp.size()), 32'd0);
        check("rx_exp_left", 32'(rx_exp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every data path.
REQ-002 Parameter FIFO_DEPTH, default 4: entries per FIFO; power of two, at least 2.
REQ-003 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 clear  input  1  asynchronous, active-low reset.
REQ-005 cpu_out_data  input  DATA_WIDTH  word driven by the datapath out-port register.
REQ-006 cpu_out_strobe  input  1  one-cycle pulse: datapath has written the out port.
REQ-007 cpu_in_data  output  DATA_WIDTH  word presented to the datapath in port (inport_data).
REQ-008 cpu_in_ready  output  1  word available to the datapath (inport_data_ready).
REQ-009 cpu_in_ack  input  1  one-cycle pulse: datapath has consumed cpu_in_data.
REQ-010 ext_tx_data / ext_tx_valid  output  DATA_WIDTH / 1  words to the external consumer.
REQ-011 ext_tx_ready  input  1  external consumer accepts a word.
REQ-012 ext_rx_data / ext_rx_valid  input  DATA_WIDTH / 1  words from the external producer.
REQ-013 ext_rx_ready  output  1  bridge accepts a word from the external producer.
REQ-014 tx_level / rx_level  output  clog2(FIFO_DEPTH)+1 each  FIFO occupancy.
REQ-015 tx_overflow / rx_underflow  output  1 each  sticky error flags.

Function
REQ-016 The TX FIFO SHALL push cpu_out_data on the rising edge where cpu_out_strobe=1 and TX is not full.
REQ-017 ext_tx_valid SHALL equal TX not-empty; ext_tx_data SHALL show the head word (show-ahead); pop on ext_tx_valid&&ext_tx_ready.
REQ-018 A word pushed into an empty TX SHALL appear on ext_tx_valid/ext_tx_data one cycle after the push edge.
REQ-019 A strobe while TX is full and not popping SHALL be dropped and SHALL set tx_overflow.
REQ-020 A strobe while TX is full and popping in the same cycle SHALL be accepted; level stays at FIFO_DEPTH; no overflow.
REQ-021 ext_rx_ready SHALL equal RX not-full; RX pushes ext_rx_data on ext_rx_valid&&ext_rx_ready.
REQ-022 cpu_in_ready SHALL equal RX not-empty; cpu_in_data SHALL be the RX head word when non-empty and 0 when empty.
REQ-023 cpu_in_ack with RX non-empty SHALL pop one word; with RX empty it SHALL be ignored and SHALL set rx_underflow.
REQ-024 Simultaneous RX push and pop SHALL leave rx_level unchanged and preserve FIFO order; the same holds for TX.
REQ-025 A pop from a full RX SHALL raise ext_rx_ready on the next cycle.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH; levels SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 Sticky flags SHALL clear only on reset.
REQ-028 tx_level and rx_level SHALL be registered counts updated on the same edge as the push/pop.

Reset
REQ-029 clear=0 SHALL immediately empty both FIFOs and zero the pointers, levels and sticky flags.
REQ-030 During reset, ext_tx_valid=0, cpu_in_ready=0, cpu_in_data=0 and ext_rx_ready=0.
REQ-031 After reset release, ext_rx_ready SHALL be 1 from the first rising edge.
REQ-032 Reset asserted mid-transfer SHALL discard all buffered words; no word is emitted after release until a new push.

Structure
REQ-033 Package io_port_pkg SHALL hold DATA_WIDTH, FIFO_DEPTH and the level/pointer width constants.
REQ-034 One sub-module, io_fifo (synchronous show-ahead FIFO with full/empty/level outputs), SHALL be instantiated twice: TX and RX.
REQ-035 All flag and handshake logic outside io_fifo SHALL live in io_port_bridge.

Verification
REQ-036 Reset, then strobe 0x0000_00A5, ext_tx_ready=1 -> ext_tx_valid high exactly one cycle later with 0x0000_00A5, tx_level returns to 0.
REQ-037 ext_tx_ready=0, five strobes 0x1..0x5 -> tx_level=4, tx_overflow=1; then drain -> 0x1,0x2,0x3,0x4 in order.
REQ-038 TX full, strobe 0x9 and ext_tx_ready=1 in the same cycle -> level stays 4, no overflow, 0x9 emitted last.
REQ-039 Push ext_rx words 0xDEAD_BEEF and 0x1234_5678 -> cpu_in_ready=1 with 0xDEAD_BEEF; ack -> 0x1234_5678; ack -> cpu_in_ready=0, cpu_in_data=0.
REQ-040 cpu_in_ack on empty RX -> rx_underflow=1, rx_level stays 0.
REQ-041 Fill RX to 4, assert clear=0 mid-cycle -> all outputs reset asynchronously; after release ext_rx_ready=1, cpu_in_ready=0.
